seq_0100_moore_no_overlap: RTL and testbench



---
 rtl/seq_0100_moore_no_overlap.sv | 63 ++++++
 tb/tb_seq_0100_moore_no_overlap.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seq_0100_moore_no_overlap.sv
// Moore detector for the serial pattern 0-1-0-0, non-overlapping, 1-cycle pulse on y.
// Optional saturating match counter: define SEQ0100_MATCH_CNT_EN.
module seq_0100_moore_no_overlap (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    output logic       y
`ifdef SEQ0100_MATCH_CNT_EN
    ,
    output logic [7:0] match_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        St0     = 3'd1,
        St01    = 3'd2,
        St010   = 3'd3,
        StMatch = 3'd4
    } state_e;

    state_e state_q, state_d;

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:  state_d = x ? StIdle : St0;
            St0:     state_d = x ? St01   : St0;
            St01:    state_d = x ? StIdle : St010;
            St010:   state_d = x ? St01   : StMatch;
            // A match restarts from scratch so no matched bit is reused
            StMatch: state_d = x ? StIdle : St0;
            default: state_d = StIdle;
        endcase
    end

    assign y = (state_q == StMatch);

`ifdef SEQ0100_MATCH_CNT_EN
    logic [7:0] cnt_q;

    // StMatch cannot follow itself, so every state_d == StMatch is a fresh entry
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= 8'd0;
        end else if (state_d == StMatch && cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_0100_moore_no_overlap.sv
// Table-driven bench for seq_0100_moore_no_overlap; counter checks run when
// SEQ0100_MATCH_CNT_EN is defined.
module tb_seq_0100_moore_no_overlap;

    logic clk;
    logic rst_n;
    logic x;
    logic y;
`ifdef SEQ0100_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int tests;
    int fails;

    seq_0100_moore_no_overlap dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y)
`ifdef SEQ0100_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic xin;
        logic yexp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic xi, input logic ye);
        vec_t v;
        v.rst  = r;
        v.xin  = xi;
        v.yexp = ye;
        vecs.push_back(v);
    endfunction

    // Adds a run of data bits (no reset); a 1 in hits marks the bit after which y must be high
    function automatic void add_bits(input logic [31:0] bits, input logic [31:0] hits,
                                     input int n);
        for (int i = n - 1; i >= 0; i--) begin
            add(1'b0, bits[i], hits[i]);
        end
    endfunction

    task automatic step(input logic r, input logic xi);
        @(negedge clk);
        rst_n = r;
        x     = xi;
        @(posedge clk);
        #1;
    endtask

    task automatic check_y(input string name, input logic exp);
        tests++;
        if (y !== exp) begin
            fails++;
            $display("FAIL %s: y=%b expected %b", name, y, exp);
        end
    endtask

`ifdef SEQ0100_MATCH_CNT_EN
    task automatic check_cnt(input string name, input logic [7:0] exp);
        tests++;
        if (match_cnt !== exp) begin
            fails++;
            $display("FAIL %s: match_cnt=%0d expected %0d", name, match_cnt, exp);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        x     = 1'b0;

        // Reset held while x toggles, then 1,0,0 from idle: nothing
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0);
        add_bits(32'b100, 32'b000, 3);
        // Basic match then exit on x=1
        add_bits(32'b01001, 32'b00010, 5);
        // Mixed stream: pulses after bits 6 and 13, bits 13-16 must not re-fire
        add(1'b1, 1'b0, 1'b0);
        add_bits(32'b00010011001001001110, 32'b00000100000010000000, 20);
        // Partial-suffix recovery through S_010 -> S_01
        add(1'b1, 1'b0, 1'b0);
        add_bits(32'b0101001, 32'b0000010, 7);
        // Back-to-back: "0100" then "100" reuses only the fresh 0 after the match
        add_bits(32'b01000100, 32'b00010001, 8);
        // Reset mid-sequence discards the 010 prefix
        add(1'b1, 1'b0, 1'b0);
        add_bits(32'b010, 32'b000, 3);
        add(1'b1, 1'b0, 1'b0);
        add_bits(32'b0110, 32'b0000, 4);
        add_bits(32'b0100, 32'b0001, 4);
        // Unused-looking input after match: 1 must return to idle, then 0100 again
        add_bits(32'b10100, 32'b00001, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].xin);
            check_y($sformatf("vec%0d", i), vecs[i].yexp);
        end

`ifdef SEQ0100_MATCH_CNT_EN
        step(1'b1, 1'b0);
        check_cnt("cnt_reset", 8'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_cnt("cnt_one", 8'd1);
        check_y("cnt_one_y", 1'b1);
        // Reset on the edge that would enter S_MATCH wins
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_cnt("cnt_rst_wins", 8'd0);
        check_y("cnt_rst_wins_y", 1'b0);
        for (int f = 1; f <= 260; f++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            if (f == 100) check_cnt("cnt_100", 8'd100);
            if (f == 255) check_cnt("cnt_255", 8'd255);
        end
        check_cnt("cnt_sat", 8'd255);
        step(1'b1, 1'b0);
        check_cnt("cnt_clear", 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
